spi_bus_master: RTL and testbench

Single-transaction SPI master that drives the memory-mapped SPI slave's `cs`/`sclk`/MOSI pins and captures its MISO data. It sits directly upstream of the slave's input conditioner and shift register. It converts one parallel request into the slave's serial frame:

- 7 address bits, then 1 R/W bit (1 = read);
- turnaround clocks;
- 8 data bits.

Read data and a completion pulse are returned to the host logic.

---
 rtl/spi_pkg.sv | 25 ++
 rtl/spi_clk_gen.sv | 59 +++++
 rtl/spi_bus_master.sv | 225 ++++++++++++++++++++++
 tb/tb_spi_bus_master.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI frame definitions used by the bus master and the slave-side FSM.
package spi_pkg;

   localparam int SPI_ADDR_W = 7;
   localparam int SPI_DATA_W = 8;
   localparam int SPI_TURN_W = 1;
   localparam int SPI_TURN_R = 2;
   localparam int SPI_TX_W   = SPI_ADDR_W + 1 + SPI_DATA_W;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_ADDR  = 3'd2,
      S_TURN  = 3'd3,
      S_DATA  = 3'd4,
      S_HOLD  = 3'd5,
      S_GAP   = 3'd6
   } spi_state_e;

   // States during which the serial clock divider runs
   function automatic logic sclk_active(input spi_state_e st);
      return (st == S_SETUP) || (st == S_ADDR) || (st == S_TURN) || (st == S_DATA);
   endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Serial clock divider: toggles sclk every CLKDIV clk cycles while enabled and
// flags the cycle in which sclk first shows a new level; clears low when disabled.
module spi_clk_gen #(
   parameter int CLKDIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic en_i,
   output logic sclk_o,
   output logic rise_stb_o,
   output logic fall_stb_o
);

   localparam int CW = (CLKDIV > 2) ? $clog2(CLKDIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          sclk_q, sclk_d;
   logic          rise_q, rise_d;
   logic          fall_q, fall_d;

   // Next-state for divider count, serial clock level and edge strobes
   always_comb begin
      cnt_d  = cnt_q;
      sclk_d = sclk_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (!en_i) begin
         cnt_d  = '0;
         sclk_d = 1'b0;
      end else if (cnt_q == CW'(CLKDIV - 1)) begin
         cnt_d  = '0;
         sclk_d = ~sclk_q;
         rise_d = ~sclk_q;
         fall_d = sclk_q;
      end else begin
         cnt_d  = cnt_q + CW'(1);
      end
   end

   // Divider state register
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         sclk_q <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         sclk_q <= sclk_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign sclk_o     = sclk_q;
   assign rise_stb_o = rise_q;
   assign fall_stb_o = fall_q;

endmodule

// File: rtl/spi_bus_master.sv
// Single-transaction SPI master: address+R/W, turnaround, 8 data bits, then cs gap.
// SPI_MASTER_MISO_SYNC_EN adds a two-flop miso synchronizer and samples on sclk falls.
module spi_bus_master
   import spi_pkg::*;
#(
   parameter int CLKDIV = 4,
   parameter int TURN_W = SPI_TURN_W,
   parameter int TURN_R = SPI_TURN_R,
   parameter int GAP    = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  rw,
   input  logic [SPI_ADDR_W-1:0] addr,
   input  logic [SPI_DATA_W-1:0] wdata,
   output logic                  busy,
   output logic                  done,
   output logic [SPI_DATA_W-1:0] rdata,
   output logic                  cs,
   output logic                  sclk,
   output logic                  mosi,
   input  logic                  miso
);

   spi_state_e            state_q, state_d;
   logic [15:0]           cnt_q, cnt_d;
   logic [SPI_TX_W-1:0]   tx_q, tx_d;
   logic [SPI_DATA_W-1:0] rx_q, rx_d;
   logic [SPI_DATA_W-1:0] rdata_q, rdata_d;
   logic                  rw_q, rw_d;
   logic                  cs_q, cs_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  mosi_q, mosi_d;
   logic                  rise_stb, fall_stb;
   logic                  smp_stb, miso_smp;
   logic [15:0]           turn_n;

   spi_clk_gen #(.CLKDIV(CLKDIV)) u_clk_gen (
      .clk        (clk),
      .reset      (reset),
      .en_i       (sclk_active(state_q)),
      .sclk_o     (sclk),
      .rise_stb_o (rise_stb),
      .fall_stb_o (fall_stb)
   );

`ifdef SPI_MASTER_MISO_SYNC_EN
   logic [1:0] sync_q;

   // Two-flop synchronizer on the incoming serial data
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], miso};
      end
   end

   assign miso_smp = sync_q[1];
   assign smp_stb  = fall_stb;
`else
   assign miso_smp = miso;
   assign smp_stb  = rise_stb;
`endif

   assign turn_n = rw_q ? 16'(TURN_R) : 16'(TURN_W);

   // Frame sequencing; mosi only updates on the cycle after an sclk fall
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      rdata_d = rdata_q;
      rw_d    = rw_q;
      cs_d    = cs_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      mosi_d  = mosi_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               rw_d    = rw;
               tx_d    = {addr, rw, (rw ? 8'h00 : wdata)};
               mosi_d  = addr[SPI_ADDR_W-1];
               rx_d    = 8'h00;
               cnt_d   = 16'd0;
               cs_d    = 1'b0;
               busy_d  = 1'b1;
               state_d = S_SETUP;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SETUP: begin
            if (rise_stb) begin
               cnt_d   = 16'd0;
               state_d = S_ADDR;
            end else begin
               state_d = S_SETUP;
            end
         end
         S_ADDR: begin
            if (fall_stb) begin
               tx_d   = {tx_q[SPI_TX_W-2:0], 1'b0};
               mosi_d = tx_q[SPI_TX_W-2];
               cnt_d  = cnt_q + 16'd1;
               if (cnt_q == 16'd7) begin
                  cnt_d = 16'd0;
                  if (turn_n == 16'd0) begin
                     state_d = S_DATA;
                  end else begin
                     mosi_d  = 1'b0;
                     state_d = S_TURN;
                  end
               end else begin
                  state_d = S_ADDR;
               end
            end else begin
               state_d = S_ADDR;
            end
         end
         S_TURN: begin
            if (fall_stb) begin
               mosi_d = 1'b0;
               cnt_d  = cnt_q + 16'd1;
               if (cnt_q == turn_n - 16'd1) begin
                  cnt_d   = 16'd0;
                  mosi_d  = tx_q[SPI_TX_W-1];
                  state_d = S_DATA;
               end else begin
                  state_d = S_TURN;
               end
            end else begin
               state_d = S_TURN;
            end
         end
         S_DATA: begin
            if (smp_stb && rw_q) begin
               rx_d = {rx_q[SPI_DATA_W-2:0], miso_smp};
            end else begin
               rx_d = rx_q;
            end
            if (fall_stb) begin
               tx_d   = {tx_q[SPI_TX_W-2:0], 1'b0};
               mosi_d = tx_q[SPI_TX_W-2];
               cnt_d  = cnt_q + 16'd1;
               if (cnt_q == 16'd7) begin
                  cnt_d   = 16'd0;
                  mosi_d  = 1'b0;
                  state_d = S_HOLD;
               end else begin
                  state_d = S_DATA;
               end
            end else begin
               state_d = S_DATA;
            end
         end
         S_HOLD: begin
            // The fall cycle already counts as the first low clock of the hold
            if (cnt_q == 16'(CLKDIV - 2)) begin
               cnt_d   = 16'd0;
               cs_d    = 1'b1;
               done_d  = 1'b1;
               rdata_d = rw_q ? rx_q : rdata_q;
               state_d = S_GAP;
            end else begin
               cnt_d   = cnt_q + 16'd1;
            end
         end
         S_GAP: begin
            if (cnt_q == 16'(GAP - 1)) begin
               cnt_d   = 16'd0;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               cnt_d   = cnt_q + 16'd1;
            end
         end
         default: begin
            cs_d    = 1'b1;
            busy_d  = 1'b0;
            mosi_d  = 1'b0;
            cnt_d   = 16'd0;
            state_d = S_IDLE;
         end
      endcase
   end

   // Frame state and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 16'd0;
         tx_q    <= '0;
         rx_q    <= 8'h00;
         rdata_q <= 8'h00;
         rw_q    <= 1'b0;
         cs_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         mosi_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         rdata_q <= rdata_d;
         rw_q    <= rw_d;
         cs_q    <= cs_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         mosi_q  <= mosi_d;
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign rdata = rdata_q;
   assign cs    = cs_q;
   assign mosi  = mosi_q;

endmodule

// File: tb/tb_spi_bus_master.sv
// Self-checking bench for spi_bus_master with a pin-level SPI slave model.
module tb_spi_bus_master;

   localparam int CLKDIV = 4;
   localparam int TURN_W = 1;
   localparam int TURN_R = 2;
   localparam int GAP    = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       rw = 1'b0;
   logic [6:0] addr = 7'h00;
   logic [7:0] wdata = 8'h00;
   logic       miso = 1'b0;
   logic       busy, done, cs, sclk, mosi;
   logic [7:0] rdata;

   int         checks = 0;
   int         failures = 0;
   logic [7:0] exp_rdata = 8'h00;

   logic [7:0] slv_data = 8'h00;
   int         slv_turn = 0;
   int         slv_cnt = 0;

   spi_bus_master #(.CLKDIV(CLKDIV), .TURN_W(TURN_W), .TURN_R(TURN_R), .GAP(GAP)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .rw    (rw),
      .addr  (addr),
      .wdata (wdata),
      .busy  (busy),
      .done  (done),
      .rdata (rdata),
      .cs    (cs),
      .sclk  (sclk),
      .mosi  (mosi),
      .miso  (miso)
   );

   always #5 clk = ~clk;

   // Slave: counts sclk rises, presents the next data bit after each fall
   always @(posedge sclk or negedge sclk or posedge cs) begin
      if (cs) begin
         slv_cnt <= 0;
         miso    <= 1'b0;
      end else if (sclk) begin
         slv_cnt <= slv_cnt + 1;
      end else if (slv_cnt >= 8 + slv_turn && slv_cnt < 16 + slv_turn) begin
         miso <= slv_data[7 - (slv_cnt - 8 - slv_turn)];
      end else begin
         miso <= 1'b0;
      end
   end

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      start = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({cs, sclk, mosi, busy, done} !== 5'b10000) begin
         failures++;
         $display("FAIL reset_ctrl: got cs/sclk/mosi/busy/done=%b expected 10000", {cs, sclk, mosi, busy, done});
      end
      checks++;
      if (rdata !== 8'h00) begin
         failures++;
         $display("FAIL reset_rdata: got %h expected 00", rdata);
      end
      start = 1'b0;
      reset = 1'b0;
      exp_rdata = 8'h00;
   endtask

   task automatic run_frame(input logic f_rw, input logic [6:0] f_addr, input logic [7:0] f_wdata,
                            input logic [7:0] f_sdata, input int coll, input string name);
      int          t, n, done_cyc, done_cnt, busy_lo, bad_rise;
      int          rise_cyc[$];
      logic [31:0] exp_v, got_v;
      logic        prev_sclk, cs_at_done;
      t = f_rw ? TURN_R : TURN_W;
      n = 16 + t;
      exp_v = 32'd0;
      for (int i = 6; i >= 0; i--) exp_v = {exp_v[30:0], f_addr[i]};
      exp_v = {exp_v[30:0], f_rw};
      for (int i = 0; i < t; i++) exp_v = {exp_v[30:0], 1'b0};
      for (int i = 7; i >= 0; i--) exp_v = {exp_v[30:0], (f_rw ? 1'b0 : f_wdata[i])};
      if (f_rw) exp_rdata = f_sdata;
      got_v = 32'd0;
      done_cyc = -1; done_cnt = 0; busy_lo = -1; cs_at_done = 1'b0; prev_sclk = 1'b0;
      slv_data = f_sdata;
      slv_turn = t;
      @(negedge clk);
      rw = f_rw; addr = f_addr; wdata = f_wdata; start = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 400 && busy_lo < 0; c++) begin
         @(negedge clk);
         if (c == 1) begin
            start = 1'b0;
            checks++;
            if (busy !== 1'b1 || cs !== 1'b0) begin
               failures++;
               $display("FAIL %s_accept: got busy=%b cs=%b expected busy=1 cs=0", name, busy, cs);
            end
         end
         if (sclk === 1'b1 && prev_sclk === 1'b0) begin
            rise_cyc.push_back(c);
            got_v = {got_v[30:0], mosi};
         end
         prev_sclk = sclk;
         if (done === 1'b1) begin
            done_cnt++;
            if (done_cyc < 0) begin
               done_cyc = c;
               cs_at_done = cs;
            end
         end
         if (c > 1 && busy === 1'b0) busy_lo = c;
         if (coll > 0 && c == coll) begin
            start = 1'b1; rw = ~f_rw; addr = ~f_addr; wdata = ~f_wdata;
         end else if (coll > 0 && c == coll + 1) begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      bad_rise = -1;
      foreach (rise_cyc[k]) if (bad_rise < 0 && rise_cyc[k] != 1 + (2 * k + 1) * CLKDIV) bad_rise = k + 1;
      checks++;
      if (rise_cyc.size() != n) begin
         failures++;
         $display("FAIL %s_rises: got %0d sclk rises expected %0d", name, rise_cyc.size(), n);
      end
      checks++;
      if (bad_rise >= 0) begin
         failures++;
         $display("FAIL %s_rise_time: rise %0d at cycle %0d expected %0d", name, bad_rise,
                  rise_cyc[bad_rise-1], 1 + (2 * bad_rise - 1) * CLKDIV);
      end
      checks++;
      if (got_v !== exp_v) begin
         failures++;
         $display("FAIL %s_mosi: got %b expected %b", name, got_v, exp_v);
      end
      checks++;
      if (done_cyc != 1 + (2 * n + 1) * CLKDIV || done_cnt != 1) begin
         failures++;
         $display("FAIL %s_done: got cycle %0d count %0d expected cycle %0d count 1", name, done_cyc,
                  done_cnt, 1 + (2 * n + 1) * CLKDIV);
      end
      checks++;
      if (cs_at_done !== 1'b1) begin
         failures++;
         $display("FAIL %s_cs_at_done: got %b expected 1", name, cs_at_done);
      end
      checks++;
      if (busy_lo != 1 + (2 * n + 1) * CLKDIV + GAP) begin
         failures++;
         $display("FAIL %s_busy_low: got cycle %0d expected %0d", name, busy_lo, 1 + (2 * n + 1) * CLKDIV + GAP);
      end
      checks++;
      if (rdata !== exp_rdata) begin
         failures++;
         $display("FAIL %s_rdata: got %h expected %h", name, rdata, exp_rdata);
      end
   endtask

   task automatic test_write();
      run_frame(1'b0, 7'h55, 8'hA3, 8'h00, 0, "write");
   endtask

   task automatic test_read();
      run_frame(1'b1, 7'h12, 8'($urandom), 8'hC6, 0, "read");
   endtask

   task automatic test_collision();
      run_frame(1'b0, 7'($urandom), 8'($urandom), 8'h00, 50, "collide");
   endtask

   task automatic test_abort();
      int done_seen;
      test_reset();
      done_seen = 0;
      slv_data = 8'hFF;
      slv_turn = TURN_R;
      @(negedge clk);
      rw = 1'b1; addr = 7'($urandom); start = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 61; c++) begin
         @(negedge clk);
         if (c == 1) start = 1'b0;
         if (done === 1'b1) done_seen++;
         if (c == 60) reset = 1'b1;
      end
      checks++;
      if ({cs, sclk, mosi, busy} !== 4'b1000) begin
         failures++;
         $display("FAIL abort_pins: got cs/sclk/mosi/busy=%b expected 1000", {cs, sclk, mosi, busy});
      end
      reset = 1'b0;
      repeat (200) begin
         @(negedge clk);
         if (done === 1'b1) done_seen++;
      end
      checks++;
      if (done_seen != 0) begin
         failures++;
         $display("FAIL abort_done: got %0d done pulses expected 0", done_seen);
      end
      checks++;
      if (rdata !== exp_rdata) begin
         failures++;
         $display("FAIL abort_rdata: got %h expected %h", rdata, exp_rdata);
      end
      run_frame(1'b0, 7'($urandom), 8'($urandom), 8'h00, 0, "post_abort");
   endtask

   task automatic test_random();
      for (int i = 0; i < 6; i++) begin
         run_frame(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 0, "random");
      end
   endtask

   task automatic test_back_to_back();
      int   busy_lo, cs_fall, c;
      logic prev_cs;
      busy_lo = -1; cs_fall = -1; prev_cs = 1'b1;
      @(negedge clk);
      rw = 1'b0; addr = 7'($urandom); wdata = 8'($urandom); start = 1'b1;
      @(posedge clk);
      c = 0;
      while (c < 400 && cs_fall < 0) begin
         c++;
         @(negedge clk);
         if (busy_lo < 0 && c > 1 && busy === 1'b0) busy_lo = c;
         if (busy_lo > 0 && prev_cs === 1'b1 && cs === 1'b0) cs_fall = c;
         prev_cs = cs;
      end
      start = 1'b0;
      checks++;
      if (busy_lo != 1 + 35 * CLKDIV + GAP) begin
         failures++;
         $display("FAIL b2b_busy_low: got cycle %0d expected %0d", busy_lo, 1 + 35 * CLKDIV + GAP);
      end
      checks++;
      if (cs_fall != busy_lo + 1) begin
         failures++;
         $display("FAIL b2b_cs_fall: got cycle %0d expected %0d", cs_fall, busy_lo + 1);
      end
      c = 0;
      while (c < 400 && busy !== 1'b0) begin
         c++;
         @(negedge clk);
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL b2b_drain: got busy=%b expected 0", busy);
      end
      checks++;
      if (rdata !== exp_rdata) begin
         failures++;
         $display("FAIL b2b_rdata: got %h expected %h", rdata, exp_rdata);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_collision();
      test_random();
      test_abort();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
